// File: rtl/pcie_tx_fc_gate.sv
// TX flow-control gate: buffers TLP beats and releases a TLP only when P/NP credits cover it.
// Optional macro PCIE_FC_STALL_CNT_EN enables the saturating credit-stall cycle counter.
module pcie_tx_fc_gate #(
    parameter int          PAYLOAD_WIDTH = 256,
    parameter int          FIFO_DEPTH    = 16,
    parameter logic [7:0]  INIT_P_HDR    = 8'd32,
    parameter logic [11:0] INIT_P_DATA   = 12'd256,
    parameter logic [7:0]  INIT_NP_HDR   = 8'd32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     tlp_in_valid,
    input  logic [PAYLOAD_WIDTH-1:0] tlp_in_data,
    input  logic                     tlp_in_last,
    output logic                     tlp_out_valid,
    output logic [PAYLOAD_WIDTH-1:0] tlp_out_data,
    output logic                     tlp_out_last,
    input  logic                     tlp_out_ready,
    input  logic                     fc_upd_valid,
    input  logic                     fc_upd_np,
    input  logic [7:0]               fc_upd_hdr,
    input  logic [11:0]              fc_upd_data,
    output logic                     fifo_overflow,
    output logic [15:0]              fc_stall_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    // Handshake: a beat transfers on a cycle where tlp_out_valid & tlp_out_ready are both high;
    // once valid is raised it stays high with stable data/last until that transfer.

    logic [PAYLOAD_WIDTH:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [AW:0]            count_q, count_d;
    state_t                 state_q, state_d;
    logic                   held_q, held_d;
    logic                   overflow_q, overflow_d;
    logic [7:0]             p_hdr_lim_q, p_hdr_lim_d;
    logic [11:0]            p_data_lim_q, p_data_lim_d;
    logic [7:0]             np_hdr_lim_q, np_hdr_lim_d;
    logic [7:0]             p_hdr_cons_q, p_hdr_cons_d;
    logic [11:0]            p_data_cons_q, p_data_cons_d;
    logic [7:0]             np_hdr_cons_q, np_hdr_cons_d;

    logic                     empty, full, push, pop, drop, out_valid;
    logic [PAYLOAD_WIDTH-1:0] head_data;
    logic                     head_last;
    logic                     is_p;
    logic [9:0]               len;
    logic [11:0]              req_data;
    logic [7:0]               p_hdr_room, np_hdr_room;
    logic [11:0]              p_data_room;
    logic                     credit_ok;

    assign empty     = (count_q == '0);
    assign full      = (count_q == DEPTH_C);
    assign head_data = mem_q[rd_ptr_q][PAYLOAD_WIDTH-1:0];
    assign head_last = mem_q[rd_ptr_q][PAYLOAD_WIDTH];

    // Header DW0 occupies the top 32 bits: fmt[1] is DW0[30], length is DW0[9:0].
    assign is_p = head_data[PAYLOAD_WIDTH-2];
    assign len  = head_data[PAYLOAD_WIDTH-32 +: 10];

    always_comb begin
        req_data = ({2'b00, len} + 12'd3) >> 2;
        if (len == 10'd0) begin
            req_data = 12'd256;
        end
    end

    // Modular room test: what remains after this TLP must lie in the lower half of the field.
    assign p_hdr_room  = p_hdr_lim_q - (p_hdr_cons_q + 8'd1);
    assign p_data_room = p_data_lim_q - (p_data_cons_q + req_data);
    assign np_hdr_room = np_hdr_lim_q - (np_hdr_cons_q + 8'd1);
    assign credit_ok   = is_p ? ((p_hdr_room <= 8'd128) && (p_data_room <= 12'd2048))
                              : (np_hdr_room <= 8'd128);

    // held_q keeps an offered head valid even if a later limit update would fail the check.
    assign out_valid = (state_q == SEND) ? !empty : (!empty && (credit_ok || held_q));
    assign pop       = out_valid && tlp_out_ready;
    assign push      = tlp_in_valid && (!full || pop);
    assign drop      = tlp_in_valid && full && !pop;

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        state_d       = state_q;
        held_d        = held_q;
        overflow_d    = overflow_q | drop;
        p_hdr_lim_d   = p_hdr_lim_q;
        p_data_lim_d  = p_data_lim_q;
        np_hdr_lim_d  = np_hdr_lim_q;
        p_hdr_cons_d  = p_hdr_cons_q;
        p_data_cons_d = p_data_cons_q;
        np_hdr_cons_d = np_hdr_cons_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (fc_upd_valid) begin
            if (fc_upd_np) begin
                np_hdr_lim_d = fc_upd_hdr;
            end else begin
                p_hdr_lim_d  = fc_upd_hdr;
                p_data_lim_d = fc_upd_data;
            end
        end

        case (state_q)
            IDLE: begin
                held_d = out_valid && !tlp_out_ready;
                if (pop) begin
                    if (is_p) begin
                        p_hdr_cons_d  = p_hdr_cons_q + 8'd1;
                        p_data_cons_d = p_data_cons_q + req_data;
                    end else begin
                        np_hdr_cons_d = np_hdr_cons_q + 8'd1;
                    end
                    if (!head_last) begin
                        state_d = SEND;
                    end
                end
            end
            SEND: begin
                held_d = 1'b0;
                if (pop && head_last) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                held_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            state_q       <= IDLE;
            held_q        <= 1'b0;
            overflow_q    <= 1'b0;
            p_hdr_lim_q   <= INIT_P_HDR;
            p_data_lim_q  <= INIT_P_DATA;
            np_hdr_lim_q  <= INIT_NP_HDR;
            p_hdr_cons_q  <= '0;
            p_data_cons_q <= '0;
            np_hdr_cons_q <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            state_q       <= state_d;
            held_q        <= held_d;
            overflow_q    <= overflow_d;
            p_hdr_lim_q   <= p_hdr_lim_d;
            p_data_lim_q  <= p_data_lim_d;
            np_hdr_lim_q  <= np_hdr_lim_d;
            p_hdr_cons_q  <= p_hdr_cons_d;
            p_data_cons_q <= p_data_cons_d;
            np_hdr_cons_q <= np_hdr_cons_d;
        end
    end

    // Storage needs no reset: every read of it is qualified by the reset count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {tlp_in_last, tlp_in_data};
        end
    end

    assign tlp_out_valid = out_valid;
    assign tlp_out_data  = out_valid ? head_data : '0;
    assign tlp_out_last  = out_valid && head_last;
    assign fifo_overflow = overflow_q;

`ifdef PCIE_FC_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == IDLE) && !empty && !credit_ok && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fc_stall_cnt = stall_cnt_q;
`else
    assign fc_stall_cnt = 16'h0;
`endif

endmodule
